// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with a small circular fetch queue.
// Each fetch reads one aligned 8-byte memory line. The line is queued as an
// aligned PC, two 32-bit instruction words and a mask of the valid words.
// A redirect (branch or exception) flushes the queue and reloads the PC.
// Optional feature: define FETCH_PERF_EN to add the stall_cnt output. This
// counter counts the cycles in which fetch was blocked by a full queue.
module inst_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [63:0] mem_addr,
   input  logic [63:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_inst0,
   output logic [31:0] out_inst1,
   output logic [1:0]  out_mask
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

   // The PC is always word aligned, so bits [1:0] are never stored.
   logic [63:2]   pc;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic [63:3]   q_pc    [QDEPTH];
   logic [31:0]   q_inst0 [QDEPTH];
   logic [31:0]   q_inst1 [QDEPTH];
   logic [1:0]    q_mask  [QDEPTH];

   logic          do_fetch;
   logic          do_deq;
   logic [1:0]    fetch_mask;
   logic          unused_bits;

   // The low bits of the redirect target are dropped on purpose.
   assign unused_bits = ^redirect_pc[1:0];

   // Fetch/dequeue decisions and the zero-latency view of the queue head.
   always_comb begin
      mem_addr   = {pc[63:3], 3'b000};
      out_valid  = (count != '0) && !redirect_valid;
      do_fetch   = !redirect_valid && (count != DEPTH_C);
      do_deq     = out_valid && out_ready;
      fetch_mask = pc[2] ? 2'b10 : 2'b11;
      out_pc     = {q_pc[rd_ptr], 3'b000};
      out_inst0  = q_inst0[rd_ptr];
      out_inst1  = q_inst1[rd_ptr];
      out_mask   = q_mask[rd_ptr];
   end

   // PC sequencing: reset beats redirect, and redirect beats a normal fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC[63:2];
      end else if (redirect_valid) begin
         pc <= redirect_pc[63:2];
      end else if (do_fetch) begin
         pc <= {pc[63:3] + 61'd1, 1'b0};
      end
   end

   // Queue bookkeeping: a redirect or reset flushes the queue by clearing
   // the pointers. Otherwise the count moves by (enqueue - dequeue).
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_fetch) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_deq) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_fetch, do_deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage has no reset; entries only matter while the count covers them.
   always_ff @(posedge clk) begin
      if (!rst && do_fetch) begin
         q_pc[wr_ptr]    <= pc[63:3];
         q_inst0[wr_ptr] <= mem_rdata[31:0];
         q_inst1[wr_ptr] <= mem_rdata[63:32];
         q_mask[wr_ptr]  <= fetch_mask;
      end
   end

`ifdef FETCH_PERF_EN
   // Count the cycles lost to a full queue that no redirect is flushing.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!redirect_valid && (count == DEPTH_C)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, shall be the fetch PC loaded on reset.
REQ-002 Parameter QDEPTH, default 4 (power of two, 2..16), shall be the fetch-queue depth in entries.
REQ-003 clk  input  1  shall be the sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  shall be the synchronous, active-high reset.
REQ-005 mem_addr  output  64  shall be the 8-byte-aligned byte address driven to instruction memory.
REQ-006 mem_rdata  input  64  shall be the combinational memory read data for mem_addr, little-endian.
REQ-007 redirect_valid  input  1  shall be the branch/exception redirect request.
REQ-008 redirect_pc  input  64  shall be the redirect target; bits [1:0] ignored.
REQ-009 out_valid  output  1  shall mark the queue head valid toward decode.
REQ-010 out_ready  input  1  shall be decode accept; a transfer occurs when out_valid && out_ready.
REQ-011 out_pc  output  64  shall be the aligned PC of the head entry.
REQ-012 out_inst0 / out_inst1  output  32 each  shall be head-entry words at out_pc and out_pc+4.
REQ-013 out_mask  output  2  shall mark the valid words: bit0 for inst0, bit1 for inst1.
REQ-014 stall_cnt  output  32  shall exist only when FETCH_PERF_EN is defined.

Function
REQ-015 mem_addr shall equal {pc[63:3],3'b000} combinationally.
REQ-016 A fetch shall occur in any cycle with !redirect_valid and count<QDEPTH; full with simultaneous dequeue shall not fetch.
REQ-017 A fetch shall enqueue {aligned pc, mem_rdata[31:0], mem_rdata[63:32], mask} and set pc <= aligned pc + 8.
REQ-018 Fetch mask shall be 2'b10 when pc[2]=1, else 2'b11.
REQ-019 Queue shall be a circular FIFO with wr/rd pointers wrapping modulo QDEPTH and count 0..QDEPTH.
REQ-020 out_valid shall be (count!=0) && !redirect_valid; out_* shall reflect the head entry with zero latency.
REQ-021 Dequeue shall advance rd pointer on out_valid && out_ready; count shall update by +enq-deq in the same edge.
REQ-022 Memory-to-out latency shall be one cycle: data fetched at edge N is visible at out_* after edge N when queue was empty.
REQ-023 Redirect shall take priority: on the edge with redirect_valid, pointers and count shall clear, pc <= {redirect_pc[63:2],2'b00}, no enqueue, no dequeue.
REQ-024 First fetch after redirect shall use the new pc in the following cycle.
REQ-025 Back-to-back redirects shall each reload pc; the last one wins.
REQ-026 When count==0, out_pc/out_inst*/out_mask values shall be don't-care; out_valid shall be 0.

Reset
REQ-027 On rst high at a rising edge: pc <= RESET_PC, count/pointers <= 0, stall_cnt <= 0; out_valid shall be 0 the following cycle.
REQ-028 rst shall override redirect_valid and any in-flight fetch/dequeue; queue contents are discarded.
REQ-029 First fetch after reset shall occur in the first cycle with rst low.

Configuration
REQ-030 Macro FETCH_PERF_EN defined: stall_cnt shall increment (wrapping at 2^32) each cycle with !rst, !redirect_valid and count==QDEPTH.
REQ-031 Macro FETCH_PERF_EN undefined: stall_cnt port and counter logic shall be absent; all other behaviour identical.

Verification
REQ-032 Reset, RESET_PC=0, memory words 0x1B40D595 at 0 and 4, out_ready=1 -> mem_addr=0; next cycle out_valid=1, out_pc=0, out_inst0=out_inst1=0x1B40D595, out_mask=2'b11.
REQ-033 out_ready=0 from reset, QDEPTH=4 -> fetches at PCs 0,8,16,24; mem_addr holds 32 while full; with FETCH_PERF_EN stall_cnt=3 after 3 further cycles.
REQ-034 Full queue, out_ready=1 for one cycle -> one dequeue (out_pc 0 -> 8), no fetch that edge; fetch at 32 next cycle.
REQ-035 redirect_valid with redirect_pc=0x10C while count=3 -> out_valid=0 that cycle; next cycle mem_addr=0x108; entry emerges with out_pc=0x108, out_mask=2'b10.
REQ-036 rst asserted with count=2 and redirect_valid=1 -> after edge count=0, pc=RESET_PC, stall_cnt=0.
REQ-037 Random out_ready over 1000 cycles, no redirects -> out_pc sequence strictly +8, no loss/duplication.
